fifo_buffer: RTL and testbench

- 16-bit first-in/first-out queue. Words are written at the tail and read from the head, the opposite end of the LIFO stack.
- Used as the in-order staging buffer between producer and consumer blocks in the final design.
- Single clock, registered flags, one-cycle read latency.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_mem.sv | 44 ++++
 rtl/fifo_buffer.sv | 137 +++++++++++++
 tb/tb_fifo_buffer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and types for the fifo_buffer staging queue.
package fifo_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_PTR_W  = $clog2(DEF_DEPTH);

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_PTR_W-1:0]  ptr_t;
  typedef logic [DEF_PTR_W:0]    cnt_t;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Storage array for fifo_buffer: one synchronous write port, one synchronous
// read port. The array itself is never reset; only the read-data register is,
// so the queue output comes up as zero.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [PTR_W-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [PTR_W-1:0]  rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Write port: store the word at the tail slot when the write is accepted.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port: capture the head word (old contents on a same-slot write), hold otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= {DATA_W{1'b0}};
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end else begin
      rd_data_q <= rd_data_q;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule : fifo_mem

// File: rtl/fifo_buffer.sv
// In-order staging FIFO between producer and consumer blocks.
// Single clock, registered flags, one-cycle read latency, no fall-through.
// Optional sticky OVF/UNF error flags are built when FIFO_ERR_FLAGS_EN is defined.
module fifo_buffer
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,   // power of 2, at least 2
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              WrEn,
  input  logic              RdEn,
  output logic [DATA_W-1:0] dataOut,
  output logic              dataValid,
  output logic              EMPTY,
  output logic              FULL,
`ifdef FIFO_ERR_FLAGS_EN
  output logic              OVF,
  output logic              UNF,
`endif
  output logic [PTR_W:0]    count
);

  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             valid_q;
  logic             wr_acc_s;
  logic             rd_acc_s;
  logic             mem_wr_s;
  logic             mem_rd_s;

  // A write is taken when there is room, or when a read frees the head slot
  // in the same cycle (full && RdEn implies not empty, so that read is taken).
  assign wr_acc_s = WrEn & (~full_q | RdEn);
  assign rd_acc_s = RdEn & ~empty_q;

  // Reset beats any request in the same cycle, including the array write.
  assign mem_wr_s = wr_acc_s & ~Rst;
  assign mem_rd_s = rd_acc_s & ~Rst;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .wr_en_i   (mem_wr_s),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (dataIn),
    .rd_en_i   (mem_rd_s),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (dataOut)
  );

  // Next pointers, count and flags; flags derive from next count so they track it exactly.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_acc_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == CNT_W'(0));
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  // Pointer, count, flag and read-valid registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      valid_q  <= rd_acc_s;
    end
  end

  assign count     = count_q;
  assign EMPTY     = empty_q;
  assign FULL      = full_q;
  assign dataValid = valid_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky error flags: a dropped write sets OVF, a dropped read sets UNF.
  always_comb begin
    ovf_d = ovf_q | (WrEn & full_q & ~RdEn);
    unf_d = unf_q | (RdEn & empty_q);
  end

  // Error flag registers, cleared only by reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign OVF = ovf_q;
  assign UNF = unf_q;
`endif

endmodule : fifo_buffer

// File: tb/tb_fifo_buffer.sv
// Self-checking bench for fifo_buffer: directed boundary steps followed by a
// random phase, all compared against a queue-based reference model.
module tb_fifo_buffer;
  import fifo_pkg::*;

  localparam int DEPTH = DEF_DEPTH;

  logic  Clk;
  logic  Rst;
  data_t dataIn;
  logic  WrEn;
  logic  RdEn;
  data_t dataOut;
  logic  dataValid;
  logic  EMPTY;
  logic  FULL;
  cnt_t  count;
`ifdef FIFO_ERR_FLAGS_EN
  logic  OVF;
  logic  UNF;
  logic  m_ovf;
  logic  m_unf;
`endif

  fifo_buffer dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .dataIn    (dataIn),
    .WrEn      (WrEn),
    .RdEn      (RdEn),
    .dataOut   (dataOut),
    .dataValid (dataValid),
    .EMPTY     (EMPTY),
    .FULL      (FULL),
`ifdef FIFO_ERR_FLAGS_EN
    .OVF       (OVF),
    .UNF       (UNF),
`endif
    .count     (count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model state
  data_t m_q[$];
  data_t m_out;
  logic  m_valid;

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the queue rules, compare everything.
  task automatic step(input logic rst, input logic wr, input logic rd, input data_t d);
    logic was_full;
    logic was_empty;
    Rst = rst; WrEn = wr; RdEn = rd; dataIn = d;
    @(posedge Clk);
    #1;
    if (rst) begin
      m_q.delete();
      m_out   = 16'h0000;
      m_valid = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
      m_ovf = 1'b0;
      m_unf = 1'b0;
`endif
    end else begin
      was_full  = (m_q.size() == DEPTH);
      was_empty = (m_q.size() == 0);
      m_valid   = 1'b0;
      if (rd && !was_empty) begin
        m_out   = m_q.pop_front();
        m_valid = 1'b1;
      end
      if (wr && (!was_full || rd)) m_q.push_back(d);
`ifdef FIFO_ERR_FLAGS_EN
      if (wr && was_full && !rd) m_ovf = 1'b1;
      if (rd && was_empty) m_unf = 1'b1;
`endif
    end
    chk("count", 32'(count), 32'(m_q.size()));
    chk("EMPTY", 32'(EMPTY), 32'(m_q.size() == 0));
    chk("FULL", 32'(FULL), 32'(m_q.size() == DEPTH));
    chk("dataValid", 32'(dataValid), 32'(m_valid));
    chk("dataOut", 32'(dataOut), 32'(m_out));
`ifdef FIFO_ERR_FLAGS_EN
    chk("OVF", 32'(OVF), 32'(m_ovf));
    chk("UNF", 32'(UNF), 32'(m_unf));
`endif
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    Rst = 1'b1; WrEn = 1'b0; RdEn = 1'b0; dataIn = 16'h0000;
    m_out = 16'h0000; m_valid = 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
    m_ovf = 1'b0; m_unf = 1'b0;
`endif

    // Reset for two cycles with a write pending: nothing may be stored
    step(1'b1, 1'b1, 1'b0, 16'hAAAA);
    step(1'b1, 1'b1, 1'b0, 16'hAAAA);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dataOut", 32'(dataOut), 32'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("rst_nowrite_empty", 32'(EMPTY), 32'd1);

    // Fill, then an overflowing write
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 16'h1000 + 16'(i));
    chk("fill_count", 32'(count), 32'd16);
    chk("fill_full", 32'(FULL), 32'd1);
    step(1'b0, 1'b1, 1'b0, 16'hDEAD);
    chk("ovf_count", 32'(count), 32'd16);

    // Drain in order, then an underflowing read
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'h0000);
      chk("drain_data", 32'(dataOut), 32'h1000 + 32'(i));
    end
    chk("drain_empty", 32'(EMPTY), 32'd1);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    chk("unf_valid", 32'(dataValid), 32'd0);

    // Wrap-around
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 16'h3000 + 16'(i));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 16'h2000 + 16'(i));
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'h0000);
      chk("wrap_data", 32'(dataOut), 32'h2000 + 32'(i));
    end

    // Simultaneous read and write at FULL
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 16'h4000 + 16'(i));
    step(1'b0, 1'b1, 1'b1, 16'hBEEF);
    chk("full_rw_head", 32'(dataOut), 32'h4000);
    chk("full_rw_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, 16'h0000);
    chk("full_rw_tail", 32'(dataOut), 32'hBEEF);

    // Simultaneous read and write at EMPTY: no fall-through
    step(1'b0, 1'b1, 1'b1, 16'h0042);
    chk("empty_rw_valid", 32'(dataValid), 32'd0);
    chk("empty_rw_count", 32'(count), 32'd1);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    chk("empty_rw_data", 32'(dataOut), 32'h0042);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 16'h5000 + 16'(i));
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    chk("midrst_count", 32'(count), 32'd0);
    step(1'b0, 1'b1, 1'b0, 16'h0007);
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    chk("midrst_data", 32'(dataOut), 32'h0007);
    step(1'b0, 1'b0, 1'b0, 16'h0000);

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           16'($urandom()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fifo_buffer
